// File: rtl/move_buffer_pkg.sv
// move_buffer_pkg: shared constants for the move segment buffer.
//   MB_DEPTH      - number of segment entries (power of two, 2..16)
//   MB_DEPTH_BITS - log2(MB_DEPTH), pointer index width
//   MB_WORD_W     - width of the duration/increment/incinc fields
//   segment_t     - one complete move segment, packed
package move_buffer_pkg;

  localparam int MB_DEPTH      = 4;
  localparam int MB_DEPTH_BITS = 2;
  localparam int MB_WORD_W     = 64;

  typedef struct packed {
    logic                 dir;
    logic [MB_WORD_W-1:0] duration;
    logic [MB_WORD_W-1:0] increment;
    logic [MB_WORD_W-1:0] incinc;
  } segment_t;

endpackage

// File: rtl/move_buffer_if.sv
// move_buffer_if: producer/consumer handshake and status bundle of the
// move segment buffer.
//   wr_*            - producer side (valid/ready plus segment fields)
//   rd_*            - consumer side (valid/ready plus head segment fields)
//   flush           - discard all queued segments
//   level/overflow  - occupancy and sticky write-while-full flag
//   clear_overflow  - clears the sticky flag
// Modports: slave = the buffer, master = the surrounding logic.
interface move_buffer_if
  import move_buffer_pkg::*;
#(
  parameter int WORD_W     = MB_WORD_W,
  parameter int DEPTH_BITS = MB_DEPTH_BITS
);

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_dir;
  logic [WORD_W-1:0] wr_duration;
  logic [WORD_W-1:0] wr_increment;
  logic [WORD_W-1:0] wr_incinc;

  logic              rd_valid;
  logic              rd_ready;
  logic              rd_dir;
  logic [WORD_W-1:0] rd_duration;
  logic [WORD_W-1:0] rd_increment;
  logic [WORD_W-1:0] rd_incinc;

  logic                  flush;
  logic [DEPTH_BITS:0]   level;
  logic                  overflow;
  logic                  clear_overflow;

  modport slave (
    input  wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
    output wr_ready,
    output rd_valid, rd_dir, rd_duration, rd_increment, rd_incinc,
    input  rd_ready,
    input  flush, clear_overflow,
    output level, overflow
  );

  modport master (
    output wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
    input  wr_ready,
    input  rd_valid, rd_dir, rd_duration, rd_increment, rd_incinc,
    output rd_ready,
    output flush, clear_overflow,
    input  level, overflow
  );

endinterface

// File: rtl/move_buffer.sv
// move_buffer: first-word-fall-through FIFO of coordinated-move segments
// between the SPI command decoder and the DDA step executor.
// Ports:
//   CLK   - system clock
//   reset - asynchronous, active-high reset
//   bus   - move_buffer_if.slave: write handshake, read handshake with the
//           head segment presented combinationally, flush, level,
//           sticky overflow and its clear.
module move_buffer
  import move_buffer_pkg::*;
#(
  parameter int DEPTH      = MB_DEPTH,
  parameter int DEPTH_BITS = MB_DEPTH_BITS,
  parameter int WORD_W     = MB_WORD_W
) (
  input  logic               CLK,
  input  logic               reset,
  move_buffer_if.slave       bus
);

  localparam logic [DEPTH_BITS:0] PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0] level_q, level_d;
  logic                overflow_q, overflow_d;

  logic              mem_dir [DEPTH];
  logic [WORD_W-1:0] mem_dur [DEPTH];
  logic [WORD_W-1:0] mem_inc [DEPTH];
  logic [WORD_W-1:0] mem_ii  [DEPTH];

  logic [DEPTH_BITS-1:0] wr_idx, rd_idx;
  logic                  empty, full, push, pop;

  assign wr_idx = wr_ptr_q[DEPTH_BITS-1:0];
  assign rd_idx = rd_ptr_q[DEPTH_BITS-1:0];

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

  // Handshake readiness comes only from registered pointers.
  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;

  assign push = bus.wr_valid && !full;
  assign pop  = bus.rd_ready && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + PTR_ONE;
      else if (pop && !push) level_d = level_q - PTR_ONE;
    end

    // Set wins over clear so a coinciding overflow is never lost.
    if (bus.clear_overflow)      overflow_d = 1'b0;
    if (bus.wr_valid && full)    overflow_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push && !bus.flush) begin
      mem_dir[wr_idx] <= bus.wr_dir;
      mem_dur[wr_idx] <= bus.wr_duration;
      mem_inc[wr_idx] <= bus.wr_increment;
      mem_ii[wr_idx]  <= bus.wr_incinc;
    end
  end

  // Head fields read as zero when empty so stale entries never leak out.
  assign bus.rd_dir       = empty ? 1'b0 : mem_dir[rd_idx];
  assign bus.rd_duration  = empty ? '0   : mem_dur[rd_idx];
  assign bus.rd_increment = empty ? '0   : mem_inc[rd_idx];
  assign bus.rd_incinc    = empty ? '0   : mem_ii[rd_idx];

  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_move_buffer.sv
module tb_move_buffer;
  import move_buffer_pkg::*;

  localparam int DEPTH = MB_DEPTH;

  logic CLK;
  logic reset;

  move_buffer_if #(.WORD_W(MB_WORD_W), .DEPTH_BITS(MB_DEPTH_BITS)) bus ();

  move_buffer #(.DEPTH(MB_DEPTH), .DEPTH_BITS(MB_DEPTH_BITS), .WORD_W(MB_WORD_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  segment_t sb[$];
  int       exp_level;
  logic     exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic segment_t mk(input logic d, input logic [63:0] dur,
                                  input logic [63:0] inc, input logic [63:0] ii);
    segment_t s;
    s.dir = d; s.duration = dur; s.increment = inc; s.incinc = ii;
    return s;
  endfunction

  // One clock cycle of stimulus, entered and left just after a negedge.
  task automatic step(input logic wv, input segment_t s, input logic rr,
                      input logic fl, input logic clr);
    logic push_ok, pop_ok, ovf_evt;
    segment_t head;
    bus.wr_valid       = wv;
    bus.wr_dir         = s.dir;
    bus.wr_duration    = s.duration;
    bus.wr_increment   = s.increment;
    bus.wr_incinc      = s.incinc;
    bus.rd_ready       = rr;
    bus.flush          = fl;
    bus.clear_overflow = clr;
    #1;
    chk("wr_ready", 64'(bus.wr_ready), 64'(exp_level < DEPTH));
    chk("rd_valid", 64'(bus.rd_valid), 64'(exp_level != 0));
    if (exp_level != 0) begin
      head = sb[0];
      chk("rd_dir",       64'(bus.rd_dir), 64'(head.dir));
      chk("rd_duration",  bus.rd_duration,  head.duration);
      chk("rd_increment", bus.rd_increment, head.increment);
      chk("rd_incinc",    bus.rd_incinc,    head.incinc);
    end else begin
      chk("rd_duration_empty", bus.rd_duration, 64'd0);
    end
    push_ok = wv && (exp_level < DEPTH);
    pop_ok  = rr && (exp_level > 0);
    ovf_evt = wv && (exp_level == DEPTH);
    @(posedge CLK);
    if (fl) begin
      sb.delete();
    end else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(s);
    end
    exp_level = sb.size();
    if (ovf_evt)  exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(negedge CLK);
    chk("level",    64'(bus.level),    64'(exp_level));
    chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
  endtask

  segment_t z;

  initial begin
    z = mk(1'b0, 64'd0, 64'd0, 64'd0);
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_dir = 1'b0; bus.wr_duration = '0;
    bus.wr_increment = '0; bus.wr_incinc = '0; bus.rd_ready = 1'b0;
    bus.flush = 1'b0; bus.clear_overflow = 1'b0;
    exp_level = 0;
    exp_ovf   = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;

    // Reset state
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_level",    64'(bus.level),    64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_rd_dur",   bus.rd_duration,   64'd0);
    step(1'b0, z, 1'b0, 1'b0, 1'b0);

    // Single push into empty, visible the cycle after
    step(1'b1, mk(1'b1, 64'd100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0, 1'b0, 1'b0);
    chk("p1_rd_valid", 64'(bus.rd_valid), 64'd1);
    chk("p1_rd_dur",   bus.rd_duration,   64'd100);
    chk("p1_rd_ii",    bus.rd_incinc,     64'hFFFF_FFFF_FFFF_FFFF);
    chk("p1_level",    64'(bus.level),    64'd1);
    step(1'b0, z, 1'b1, 1'b0, 1'b0);

    // Fill, overflow attempt, drain in order, clear overflow
    for (int i = 1; i <= 4; i++)
      step(1'b1, mk(i[0], 64'(i), 64'(3 * i), -64'(i)), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 64'd5, 64'd15, -64'd5), 1'b0, 1'b0, 1'b0);
    chk("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("full_overflow", 64'(bus.overflow), 64'd1);
    chk("full_level",    64'(bus.level),    64'd4);
    // Pop while full with a write offered: no same-cycle push
    step(1'b1, mk(1'b0, 64'd6, 64'd0, 64'd0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, z, 1'b1, 1'b0, 1'b0);
    chk("drain_rd_valid", 64'(bus.rd_valid), 64'd0);
    step(1'b0, z, 1'b1, 1'b0, 1'b0);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    chk("clr_overflow", 64'(bus.overflow), 64'd0);

    // Steady-state push+pop at level 2, wrapping the pointers
    step(1'b1, mk(1'b0, 64'd200, 64'd7, 64'd1), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 64'd201, 64'd8, 64'd2), 1'b0, 1'b0, 1'b0);
    for (int i = 10; i <= 19; i++) begin
      step(1'b1, mk(i[0], 64'(i), 64'(i * 11), -64'(i)), 1'b1, 1'b0, 1'b0);
      chk("pp_level", 64'(bus.level), 64'd2);
    end
    chk("pp_head", bus.rd_duration, 64'd18);
    step(1'b0, z, 1'b1, 1'b0, 1'b0);
    step(1'b0, z, 1'b1, 1'b0, 1'b0);

    // Flush at level 3 with overflow set; flush beats push and pop
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(1'b0, 64'(300 + i), 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 64'd399, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    step(1'b0, z, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_level", 64'(bus.level), 64'd3);
    step(1'b1, mk(1'b1, 64'd500, 64'd1, 64'd1), 1'b1, 1'b1, 1'b0);
    chk("flush_level",    64'(bus.level),    64'd0);
    chk("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("flush_overflow", 64'(bus.overflow), 64'd1);
    step(1'b1, mk(1'b1, 64'd600, 64'd2, 64'd3), 1'b0, 1'b0, 1'b0);
    chk("post_flush_head", bus.rd_duration, 64'd600);

    // Set-dominant overflow: fill, then overflow event with clear
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(1'b0, 64'(700 + i), 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(1'b0, 64'd799, 64'd0, 64'd0), 1'b0, 1'b0, 1'b1);
    chk("set_dominant", 64'(bus.overflow), 64'd1);
    step(1'b0, z, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle at level 2
    step(1'b1, mk(1'b0, 64'd800, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 64'd801, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 64'(bus.level), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("async_rst_level",    64'(bus.level),    64'd0);
    @(negedge CLK);
    reset = 1'b0;
    sb.delete();
    exp_level = 0;
    exp_ovf   = 1'b0;
    step(1'b0, z, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
